// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan decoder and its pattern decoder.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg_scan_pkg;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;
   // 6 and 9 drawn without their tail segment
   localparam logic [6:0] SEG_6_NT = 7'h7C;
   localparam logic [6:0] SEG_9_NT = 7'h67;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_BAD   = 4'hE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_HOLD
   } state_e;

   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] oh2idx(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++)
         if (v[i]) r = 2'(i);
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display bus (segments, dp, digit select) plus the decoder's published results.
// master = display/bench side, slave = decoder side.
interface seg_scan_decoder_if;
   logic [6:0]  seg_in;
   logic        dp_in;
   logic [3:0]  digit_in;
   logic [15:0] digits_out;
   logic [3:0]  present_out;
   logic [3:0]  dp_out;
   logic        frame_valid;
   logic        frame_changed;
   logic        scan_lost;
   logic        err_multi;
   logic        err_pattern;

   modport master (
      output seg_in, dp_in, digit_in,
      input  digits_out, present_out, dp_out, frame_valid, frame_changed,
             scan_lost, err_multi, err_pattern
   );

   modport slave (
      input  seg_in, dp_in, digit_in,
      output digits_out, present_out, dp_out, frame_valid, frame_changed,
             scan_lost, err_multi, err_pattern
   );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to 4-bit code. SEG_DECODE_HEX_EN adds A..F;
// with it, 0x7C reads as 'b' rather than a tailless 6.
module seg7_pattern_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] pat_i,
   output logic [3:0] code_o,
   output logic       bad_o
);
   always_comb begin
      code_o = CODE_BAD;
      bad_o  = 1'b0;
      case (pat_i)
         SEG_0:           code_o = 4'd0;
         SEG_1:           code_o = 4'd1;
         SEG_2:           code_o = 4'd2;
         SEG_3:           code_o = 4'd3;
         SEG_4:           code_o = 4'd4;
         SEG_5:           code_o = 4'd5;
`ifdef SEG_DECODE_HEX_EN
         SEG_6:           code_o = 4'd6;
`else
         SEG_6, SEG_6_NT: code_o = 4'd6;
`endif
         SEG_7:           code_o = 4'd7;
         SEG_8:           code_o = 4'd8;
         SEG_9, SEG_9_NT: code_o = 4'd9;
         7'h00:           code_o = CODE_BLANK;
`ifdef SEG_DECODE_HEX_EN
         SEG_A:           code_o = 4'hA;
         SEG_B:           code_o = 4'hB;
         SEG_C:           code_o = 4'hC;
         SEG_D:           code_o = 4'hD;
         SEG_E:           code_o = 4'hE;
         SEG_F:           code_o = 4'hF;
`endif
         default:         bad_o  = 1'b1;
      endcase
   end
endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: samples settled digits,
// rebuilds 4-digit frames and publishes a frame once it repeats STABLE_FRAMES times.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int SETTLE         = 2,
   parameter int STABLE_FRAMES  = 2,
   parameter int TIMEOUT        = 1024,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input logic               clock,
   input logic               reset,
   seg_scan_decoder_if.slave bus
);
   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [3:0]    SETTLE_C = 4'(SETTLE);
   localparam logic [2:0]    STABLE_C = 3'(STABLE_FRAMES);
   localparam logic [TW-1:0] TMO_C    = TW'(TIMEOUT);

   logic [6:0]    seg_q, lseg_q, lseg_d;
   logic          dp_q, ldp_q, ldp_d;
   logic [3:0]    dig_q, sel_q, sel_d, cnt_q, cnt_d;
   state_e        state_q, state_d;
   logic [15:0]   fdig_q, fdig_d, pdig_q, pdig_d, dout_q, dout_d, bdig;
   logic [3:0]    fpres_q, fpres_d, ppres_q, ppres_d, pout_q, pout_d, bpres;
   logic [3:0]    fdp_q, fdp_d, pdp_q, pdp_d, dpout_q, dpout_d, bdp;
   logic [2:0]    match_q, match_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          fv_q, fv_d, fc_q, fc_d, lost_q, lost_d;
   logic          emulti_q, emulti_d, epat_q, epat_d;
   logic          dig_oh, same, smp, multi, tmo_hit;
   logic [3:0]    dec_code;
   logic          dec_bad;
   logic [1:0]    k;

   seg7_pattern_decode u_dec (.pat_i(seg_q), .code_o(dec_code), .bad_o(dec_bad));

   assign dig_oh = onehot4(dig_q);
   assign same   = (dig_q == sel_q) && (seg_q == lseg_q) && (dp_q == ldp_q);

   // Digit FSM: a digit is sampled once per select period, after it has settled
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      lseg_d  = lseg_q;
      ldp_d   = ldp_q;
      cnt_d   = cnt_q;
      smp     = 1'b0;
      multi   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dig_oh) begin
               state_d = S_SETTLE;
               sel_d = dig_q; lseg_d = seg_q; ldp_d = dp_q; cnt_d = 4'd0;
            end else if (dig_q != 4'd0) begin
               multi = 1'b1;
            end
         end
         S_SETTLE: begin
            if (same) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_d == SETTLE_C) begin
                  smp     = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (dig_oh) begin
               sel_d = dig_q; lseg_d = seg_q; ldp_d = dp_q; cnt_d = 4'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (dig_q != sel_q) begin
               if (dig_oh) begin
                  state_d = S_SETTLE;
                  sel_d = dig_q; lseg_d = seg_q; ldp_d = dp_q; cnt_d = 4'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame assembly, stability qualification and scan-loss tracking
   always_comb begin
      fdig_d  = fdig_q;  fpres_d = fpres_q; fdp_d   = fdp_q;
      pdig_d  = pdig_q;  ppres_d = ppres_q; pdp_d   = pdp_q;
      dout_d  = dout_q;  pout_d  = pout_q;  dpout_d = dpout_q;
      bdig    = fdig_q;  bpres   = fpres_q; bdp     = fdp_q;
      match_d = match_q;
      fv_d    = 1'b0;
      fc_d    = 1'b0;
      lost_d  = lost_q;
      k       = oh2idx(sel_q);
      emulti_d = emulti_q | multi;
      epat_d   = epat_q | (smp & dec_bad);
      tmo_hit  = !dig_oh && (tmo_q == TMO_C - TW'(1));
      if (dig_oh)             tmo_d = '0;
      else if (tmo_q != TMO_C) tmo_d = tmo_q + TW'(1);
      else                     tmo_d = tmo_q;

      // Timeout takes priority over a coincident frame closure
      if (tmo_hit) begin
         lost_d  = 1'b1;
         fdig_d  = {4{CODE_BLANK}};
         fpres_d = 4'd0;
         fdp_d   = 4'd0;
         match_d = 3'd0;
      end else if (smp) begin
         lost_d = 1'b0;
         if (fpres_q[k]) begin
            if (match_q != 3'd0 && fdig_q == pdig_q && fpres_q == ppres_q && fdp_q == pdp_q)
               match_d = (match_q == STABLE_C) ? match_q : match_q + 3'd1;
            else
               match_d = 3'd1;
            pdig_d = fdig_q; ppres_d = fpres_q; pdp_d = fdp_q;
            if (match_d == STABLE_C) begin
               dout_d  = fdig_q;
               pout_d  = fpres_q;
               dpout_d = fdp_q;
               fv_d    = 1'b1;
               fc_d    = (fdig_q != dout_q) || (fpres_q != pout_q) || (fdp_q != dpout_q);
            end
            bdig  = {4{CODE_BLANK}};
            bpres = 4'd0;
            bdp   = 4'd0;
         end
         fdig_d               = bdig;
         fdig_d[{k, 2'b00} +: 4] = dec_code;
         fpres_d              = bpres;
         fpres_d[k]           = 1'b1;
         fdp_d                = bdp;
         fdp_d[k]             = dp_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         seg_q <= '0; dp_q <= 1'b0; dig_q <= '0;
         state_q <= S_IDLE; sel_q <= '0; lseg_q <= '0; ldp_q <= 1'b0; cnt_q <= '0;
         fdig_q <= {4{CODE_BLANK}}; fpres_q <= '0; fdp_q <= '0;
         pdig_q <= {4{CODE_BLANK}}; ppres_q <= '0; pdp_q <= '0;
         dout_q <= {4{CODE_BLANK}}; pout_q <= '0; dpout_q <= '0;
         match_q <= '0; tmo_q <= '0;
         fv_q <= 1'b0; fc_q <= 1'b0; lost_q <= 1'b0; emulti_q <= 1'b0; epat_q <= 1'b0;
      end else begin
         seg_q <= SEG_ACTIVE_LOW ? ~bus.seg_in   : bus.seg_in;
         dp_q  <= SEG_ACTIVE_LOW ? ~bus.dp_in    : bus.dp_in;
         dig_q <= DIG_ACTIVE_LOW ? ~bus.digit_in : bus.digit_in;
         state_q <= state_d; sel_q <= sel_d; lseg_q <= lseg_d; ldp_q <= ldp_d; cnt_q <= cnt_d;
         fdig_q <= fdig_d; fpres_q <= fpres_d; fdp_q <= fdp_d;
         pdig_q <= pdig_d; ppres_q <= ppres_d; pdp_q <= pdp_d;
         dout_q <= dout_d; pout_q <= pout_d; dpout_q <= dpout_d;
         match_q <= match_d; tmo_q <= tmo_d;
         fv_q <= fv_d; fc_q <= fc_d; lost_q <= lost_d; emulti_q <= emulti_d; epat_q <= epat_d;
      end
   end

   assign bus.digits_out    = dout_q;
   assign bus.present_out   = pout_q;
   assign bus.dp_out        = dpout_q;
   assign bus.frame_valid   = fv_q;
   assign bus.frame_changed = fc_q;
   assign bus.scan_lost     = lost_q;
   assign bus.err_multi     = emulti_q;
   assign bus.err_pattern   = epat_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a transaction-level frame model pushes
// expected publishes as digits are driven; a monitor pops them on frame_valid.
module tb_seg_scan_decoder;
   localparam int STABLE = 2;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  pres;
      logic [3:0]  dp;
      logic        chg;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   seg_scan_decoder_if bus ();
   seg_scan_decoder u_dut (.clock(clock), .reset(reset), .bus(bus));

   int   checks = 0;
   int   errors = 0;
   int   n_valid = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   logic [15:0] m_dig, p_dig, o_dig;
   logic [3:0]  m_pres, m_dp, p_pres, p_dp, o_pres, o_dp;
   int          m_match;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] pat(input logic [3:0] c);
      case (c)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;  default: return 7'h00;
      endcase
   endfunction

   task automatic m_reset();
      m_dig = 16'hFFFF; m_pres = 4'd0; m_dp = 4'd0; m_match = 0;
      p_dig = 16'hFFFF; p_pres = 4'd0; p_dp = 4'd0;
      o_dig = 16'hFFFF; o_pres = 4'd0; o_dp = 4'd0;
   endtask

   task automatic m_lost();
      m_dig = 16'hFFFF; m_pres = 4'd0; m_dp = 4'd0; m_match = 0;
   endtask

   task automatic m_sample(input int k, input logic [3:0] code, input logic d);
      exp_t x;
      if (m_pres[k]) begin
         if (m_match != 0 && m_dig == p_dig && m_pres == p_pres && m_dp == p_dp)
            m_match = (m_match < STABLE) ? m_match + 1 : STABLE;
         else
            m_match = 1;
         p_dig = m_dig; p_pres = m_pres; p_dp = m_dp;
         if (m_match >= STABLE) begin
            x.dig  = m_dig;
            x.pres = m_pres;
            x.dp   = m_dp;
            x.chg  = (m_dig != o_dig) || (m_pres != o_pres) || (m_dp != o_dp);
            exp_q.push_back(x);
            o_dig = m_dig; o_pres = m_pres; o_dp = m_dp;
         end
         m_dig = 16'hFFFF; m_pres = 4'd0; m_dp = 4'd0;
      end
      m_dig[k*4 +: 4] = code;
      m_pres[k]       = 1'b1;
      m_dp[k]         = d;
   endtask

   // One digit slot of 8 cycles; optional 1-cycle segment glitch at its start
   task automatic dwell(input int k, input logic [6:0] p, input logic d, input logic [3:0] code,
                        input bit glitch);
      @(negedge clock);
      m_sample(k, code, d);
      bus.digit_in = 4'(1 << k);
      bus.dp_in    = d;
      bus.seg_in   = glitch ? 7'h06 : p;
      if (glitch) begin
         @(negedge clock);
         bus.seg_in = p;
      end
      repeat (glitch ? 6 : 7) @(negedge clock);
   endtask

   task automatic scan(input logic [15:0] codes, input logic [3:0] dps, input int loops);
      for (int l = 0; l < loops; l++)
         for (int k = 3; k >= 0; k--)
            dwell(k, pat(codes[k*4 +: 4]), dps[k], codes[k*4 +: 4], 1'b0);
   endtask

   task automatic idle_sel(input int n);
      @(negedge clock);
      bus.digit_in = 4'd0;
      bus.seg_in   = 7'h00;
      bus.dp_in    = 1'b0;
      repeat (n - 1) @(negedge clock);
   endtask

   always @(negedge clock) begin
      if (bus.frame_valid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(bus.frame_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pub_digits",  32'(bus.digits_out),    32'(mon_e.dig));
            chk("pub_present", 32'(bus.present_out),   32'(mon_e.pres));
            chk("pub_dp",      32'(bus.dp_out),        32'(mon_e.dp));
            chk("pub_changed", 32'(bus.frame_changed), 32'(mon_e.chg));
         end
      end
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_digits"},  32'(bus.digits_out),    32'hFFFF);
      chk({tag, "_present"}, 32'(bus.present_out),   32'd0);
      chk({tag, "_dp"},      32'(bus.dp_out),        32'd0);
      chk({tag, "_valid"},   32'(bus.frame_valid),   32'd0);
      chk({tag, "_changed"}, 32'(bus.frame_changed), 32'd0);
      chk({tag, "_lost"},    32'(bus.scan_lost),     32'd0);
      chk({tag, "_emulti"},  32'(bus.err_multi),     32'd0);
      chk({tag, "_epat"},    32'(bus.err_pattern),   32'd0);
   endtask

   int n_before;

   initial begin
      reset = 1'b1;
      bus.seg_in = 7'h00; bus.dp_in = 1'b0; bus.digit_in = 4'd0;
      m_reset();
      repeat (3) @(negedge clock);
      chk_reset_state("rst");
      reset = 1'b0;

      // "12:34" with colon on digit2: first publish after the second closed frame
      scan(16'h1234, 4'b0100, 3);
      chk("first_pub_count", 32'(n_valid), 32'd1);
      chk("d1234_digits",  32'(bus.digits_out),  32'h1234);
      chk("d1234_present", 32'(bus.present_out), 32'hF);
      chk("d1234_dp",      32'(bus.dp_out),      32'b0100);
      scan(16'h1234, 4'b0100, 2);
      chk("repeat_pub_count", 32'(n_valid), 32'd3);
      chk("no_emulti_yet", 32'(bus.err_multi),   32'd0);
      chk("no_epat_yet",   32'(bus.err_pattern), 32'd0);

      // Multi-hot select inserted between digits 2 and 1
      for (int l = 0; l < 2; l++) begin
         dwell(3, pat(4'd1), 1'b0, 4'd1, 1'b0);
         dwell(2, pat(4'd2), 1'b1, 4'd2, 1'b0);
         @(negedge clock);
         bus.digit_in = 4'b0110;
         repeat (4) @(negedge clock);
         dwell(1, pat(4'd3), 1'b0, 4'd3, 1'b0);
         dwell(0, pat(4'd4), 1'b0, 4'd4, 1'b0);
      end
      chk("emulti_set",    32'(bus.err_multi),  32'd1);
      chk("multi_digits",  32'(bus.digits_out), 32'h1234);

      // Hour-only scan "07": digits 1 and 0 never selected
      for (int l = 0; l < 4; l++) begin
         dwell(3, pat(4'd0), 1'b0, 4'd0, 1'b0);
         dwell(2, pat(4'd7), 1'b0, 4'd7, 1'b0);
         idle_sel(16);
      end
      chk("hour_digits",  32'(bus.digits_out),  32'h07FF);
      chk("hour_present", 32'(bus.present_out), 32'b1100);
      chk("hour_dp",      32'(bus.dp_out),      32'd0);

      // Unknown pattern 0x49 on digit1
      for (int l = 0; l < 3; l++) begin
         dwell(3, pat(4'd1), 1'b0, 4'd1, 1'b0);
         dwell(2, pat(4'd2), 1'b1, 4'd2, 1'b0);
         dwell(1, 7'h49,     1'b0, 4'hE, 1'b0);
         dwell(0, pat(4'd4), 1'b0, 4'd4, 1'b0);
      end
      chk("epat_set",     32'(bus.err_pattern),     32'd1);
      chk("bad_nibble",   32'(bus.digits_out[7:4]), 32'hE);
      chk("emulti_stick", 32'(bus.err_multi),       32'd1);

      // Glitched segments plus tailless 6 (0x7C) and 9 (0x67): "5689"
      for (int l = 0; l < 3; l++) begin
         dwell(3, pat(4'd5), 1'b0, 4'd5, 1'b1);
         dwell(2, 7'h7C,     1'b0, 4'd6, 1'b1);
         dwell(1, pat(4'd8), 1'b0, 4'd8, 1'b1);
         dwell(0, 7'h67,     1'b0, 4'd9, 1'b1);
      end
      chk("glitch_digits", 32'(bus.digits_out), 32'h5689);

      // Scan stops: scan_lost after ~TIMEOUT idle cycles, outputs held
      idle_sel(1);
      repeat (1021) @(negedge clock);
      chk("lost_early", 32'(bus.scan_lost), 32'd0);
      repeat (5) @(negedge clock);
      chk("lost_set", 32'(bus.scan_lost), 32'd1);
      repeat (73) @(negedge clock);
      m_lost();
      chk("lost_hold_digits", 32'(bus.digits_out), 32'h5689);
      chk("lost_level",       32'(bus.scan_lost),  32'd1);
      dwell(3, pat(4'd1), 1'b0, 4'd1, 1'b0);
      chk("lost_clear", 32'(bus.scan_lost), 32'd0);
      dwell(2, pat(4'd2), 1'b1, 4'd2, 1'b0);
      dwell(1, pat(4'd3), 1'b0, 4'd3, 1'b0);
      dwell(0, pat(4'd4), 1'b0, 4'd4, 1'b0);
      scan(16'h1234, 4'b0100, 2);
      chk("resume_digits", 32'(bus.digits_out), 32'h1234);

      // Reset in the middle of a frame
      dwell(3, pat(4'd4), 1'b0, 4'd4, 1'b0);
      dwell(2, pat(4'd3), 1'b0, 4'd3, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      bus.digit_in = 4'd0;
      m_reset();
      repeat (2) @(negedge clock);
      chk_reset_state("midrst");
      reset = 1'b0;
      n_before = n_valid;
      scan(16'h4321, 4'b0001, 2);
      chk("post_rst_nopub", 32'(n_valid), 32'(n_before));
      scan(16'h4321, 4'b0001, 1);
      chk("post_rst_pub",     32'(n_valid),        32'(n_before + 1));
      chk("post_rst_digits",  32'(bus.digits_out), 32'h4321);
      chk("post_rst_dp",      32'(bus.dp_out),     32'b0001);

      repeat (10) @(negedge clock);
      chk("pending_expect", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive end of the multiplexed 7-segment display interface driven by the clock/calendar top.
- Samples the segment bus and the digit-select bus, decodes each digit back to a 4-bit code, and assembles complete 4-digit frames.
- Publishes a frame only after it is stable across several scans.
- Used as on-chip loopback/self-check of the display path and as a bench monitor.

Parameters:
- SETTLE, 2, consecutive cycles the digit select and segments must be unchanged before a digit is sampled (1..15).
- STABLE_FRAMES, 2, consecutive identical frames required before digits_out updates (1..7).
- TIMEOUT, 1024, cycles with no valid digit select before the scan is declared lost (width = clog2(TIMEOUT+1)).
- SEG_ACTIVE_LOW, 0, 1 = segment and dp inputs are active-low.
- DIG_ACTIVE_LOW, 0, 1 = digit-select inputs are active-low.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seg_in  in  7  segments {g,f,e,d,c,b,a}
- dp_in  in  1  decimal point / colon
- digit_in  in  4  digit select; bit3 = leftmost digit
- digits_out  out  16  published codes; [15:12] = digit3
- present_out  out  4  digit seen in the published frame
- dp_out  out  4  per-digit captured dp
- frame_valid  out  1  1-cycle pulse when digits_out/present_out/dp_out update
- frame_changed  out  1  1-cycle pulse, coincident with frame_valid, when content differs from the previous publish
- scan_lost  out  1  level: no valid digit select for TIMEOUT cycles
- err_multi  out  1  sticky: digit select with more than one bit active
- err_pattern  out  1  sticky: sampled pattern decoded to 4'hE

Behaviour:
- Inputs are polarity-normalised first, then registered once; all logic below runs on the registered copy.
- Decode:
  - Patterns 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F map to codes 0..9.
  - 0x00 maps to 4'hF (blank).
  - Any other pattern maps to 4'hE.
  - 0x7D/0x6F are also accepted as 0x7C/0x67 (6/9 without tail).
- FSM states:
  - S_IDLE: wait for a one-hot select. Zero bits active stays in S_IDLE. Two or more bits active sets err_multi and stays in S_IDLE.
  - S_SETTLE: count cycles while the select and segments are unchanged. Any change returns to S_IDLE, or restarts the count if the new select is one-hot. At count == SETTLE: sample the code and dp, go to S_HOLD.
  - S_HOLD: wait until the select changes.
- Frame closure: a sample for a digit already captured in the current frame closes the frame, then that sample starts the next frame.
  - Closed frame = codes/dp of captured digits; unseen digits get code 4'hF, dp 0, present bit 0.
- Publish:
  - Closed frame equal (codes, dp, present) to the previous closed frame increments the match count; otherwise the count is reset to 1.
  - When the count reaches STABLE_FRAMES, the outputs update the same cycle.
  - frame_valid pulses the next cycle with the outputs already valid. The pulse occurs once per qualifying frame, including repeat frames.
- Timeout:
  - The timeout counter resets on every one-hot select and saturates at TIMEOUT.
  - At TIMEOUT: scan_lost=1, the current partial frame and match count are discarded, outputs are not changed.
  - scan_lost clears on the next successful sample.
- A sample with err_pattern still enters the frame with code 4'hE.
- Simultaneous frame closure and timeout: timeout wins, the frame is discarded.
- Reset values:
  - digits_out=16'hFFFF, present_out=0, dp_out=0.
  - frame_valid=0, frame_changed=0, scan_lost=0.
  - err_multi=0, err_pattern=0.
  - FSM S_IDLE, all counters 0.
- Reset mid-frame discards everything; no pulse is produced.

Optional Feature:
- SEG_DECODE_HEX_EN defined: 0x77,0x7C,0x39,0x5E,0x79,0x71 decode to codes A..F. Code 4'hE is then ambiguous, so pattern 0x79 sets no error.
- Undefined: those patterns decode to 4'hE and set err_pattern.

Decomposition:
- Shared package seg_scan_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_A..SEG_F.
  - code constants CODE_BLANK=4'hF, CODE_BAD=4'hE.
  - FSM state enum.
- One sub-module seg7_pattern_decode (combinational, 7-bit pattern to 4-bit code plus bad flag).
  - Shared with the display encoder's bench.

Test Plan:
- Scan "12:34", digit order 3,2,1,0, 8 cycles per digit, dp on digit2, three loops:
  - frame_valid first pulses after the 2nd frame closes.
  - digits_out=16'h1234, present_out=4'hF, dp_out=4'b0100, frame_changed=1.
  - Later pulses have frame_changed=0.
- Hour-only scan (digits 3,2 lit with "07"):
  - digits_out=16'h07FF, present_out=4'b1100.
- digit_in=4'b0110 for 5 cycles mid-scan:
  - err_multi=1 sticky, frame content unaffected.
- Segments 0x49 on digit1:
  - err_pattern=1, digits_out[7:4]=4'hE after publish.
- Stop the scan for 1100 cycles:
  - scan_lost=1 at cycle 1024.
  - digits_out still holds its last value.
  - Scan resumes: scan_lost=0 on the first sample.
- Glitch: segments change 1 cycle after select (SETTLE=2):
  - Only the settled value is sampled.
- Reset asserted mid-frame:
  - All outputs return to reset values.
  - No frame_valid until 2 fresh full frames.
